// File: rtl/offsets.sv
// offsets: vector bias adder that adds a per-lane offset to a data vector and
// registers the result with one cycle of latency.
//
// Ports:
//   clk_i    - system clock; all state updates on the rising edge
//   rst_i    - asynchronous active-low reset; clears data_o immediately
//   data_i   - input data vector, IN_SIZE signed elements
//   offset_i - offset (bias) vector, one signed element per lane
//   data_o   - registered element-wise sums
//
// SATURATE=0 wraps modulo 2^DATA_W; SATURATE=1 clamps to the signed range.

package types;
    typedef logic signed [15:0] data_type;
endpackage

// One lane: a sign-extended add followed by an optional clamp, then a register.
module offsets_lane #(
    parameter int DATA_W   = 16,
    parameter int SATURATE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] data,
    input  logic signed [DATA_W-1:0] offset,
    output logic signed [DATA_W-1:0] sum
);
    localparam logic signed [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W:0]   wide;
    logic signed [DATA_W-1:0] nxt;
    logic                     ovf;

    always_comb begin
        wide = {data[DATA_W-1], data} + {offset[DATA_W-1], offset};
        // The two top bits of the extended sum disagree only on overflow;
        // the extra top bit then carries the true sign of the result.
        ovf  = wide[DATA_W] ^ wide[DATA_W-1];
        nxt  = wide[DATA_W-1:0];
        if (SATURATE != 0 && ovf)
            nxt = wide[DATA_W] ? MIN_VAL : MAX_VAL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum <= '0;
        else        sum <= nxt;
    end
endmodule

module offsets #(
    parameter int IN_SIZE  = 16,
    parameter int DATA_W   = 16,
    parameter int SATURATE = 0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  types::data_type data_i   [0:IN_SIZE-1],
    input  types::data_type offset_i [0:IN_SIZE-1],
    output types::data_type data_o   [0:IN_SIZE-1]
);
    for (genvar g = 0; g < IN_SIZE; g++) begin : g_lane
        offsets_lane #(
            .DATA_W   (DATA_W),
            .SATURATE (SATURATE)
        ) u_lane (
            .clk    (clk_i),
            .rst_n  (rst_i),
            .data   (data_i[g]),
            .offset (offset_i[g]),
            .sum    (data_o[g])
        );
    end
endmodule

// File: tb/tb_offsets.sv
// Directed bench for offsets: one wrapping and one saturating instance share
// the same inputs; expected values are computed here from integer arithmetic.
module tb_offsets;
    localparam int N = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    types::data_type din  [0:N-1];
    types::data_type off  [0:N-1];
    types::data_type dw   [0:N-1];
    types::data_type ds   [0:N-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    offsets #(.IN_SIZE(N), .DATA_W(16), .SATURATE(0)) dut_w (
        .clk_i(clk), .rst_i(rst), .data_i(din), .offset_i(off), .data_o(dw));
    offsets #(.IN_SIZE(N), .DATA_W(16), .SATURATE(1)) dut_s (
        .clk_i(clk), .rst_i(rst), .data_i(din), .offset_i(off), .data_o(ds));

    task automatic chk(input string tag, input int lane, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s lane %0d: got %0d expected %0d", tag, lane, obs, exp);
        end
    endtask

    function automatic int wrap16(input int s);
        int r;
        r = s & 32'hFFFF;
        return (r >= 32768) ? r - 65536 : r;
    endfunction

    function automatic int sat16(input int s);
        return (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
    endfunction

    // Check every lane of both instances against the sum of the given inputs.
    task automatic chk_sums(input string tag, input int a [0:N-1], input int b [0:N-1]);
        for (int i = 0; i < N; i++) begin
            chk({tag, "_wrap"}, i, int'(dw[i]), wrap16(a[i] + b[i]));
            chk({tag, "_sat"},  i, int'(ds[i]), sat16(a[i] + b[i]));
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < N; i++) begin
            chk({tag, "_wrap"}, i, int'(dw[i]), 0);
            chk({tag, "_sat"},  i, int'(ds[i]), 0);
        end
    endtask

    task automatic drive(input int a [0:N-1], input int b [0:N-1]);
        for (int i = 0; i < N; i++) begin
            din[i] = types::data_type'(a[i]);
            off[i] = types::data_type'(b[i]);
        end
    endtask

    task automatic rand_vec(output int a [0:N-1], output int b [0:N-1]);
        for (int i = 0; i < N; i++) begin
            a[i] = int'($urandom_range(65535)) - 32768;
            b[i] = int'($urandom_range(65535)) - 32768;
        end
    endtask

    initial begin
        int a [0:N-1];
        int b [0:N-1];
        int pa [0:N-1];
        int pb [0:N-1];

        // Reset held low with random inputs: outputs stay zero every cycle.
        rand_vec(a, b);
        drive(a, b);
        #1;
        chk_zero("reset_t0");
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            rand_vec(a, b);
            drive(a, b);
            chk_zero("reset_hold");
        end

        // Release between edges: still zero until the next rising edge.
        rst = 1'b1;
        #2;
        chk_zero("release_pre_edge");

        // First edge after release registers the random vector.
        @(posedge clk); #1;
        chk_sums("random1", a, b);

        // Input changes between edges do not reach the output.
        pa = a; pb = b;
        rand_vec(a, b);
        drive(a, b);
        #3;
        chk_sums("mid_cycle_hold", pa, pb);
        @(posedge clk); #1;
        chk_sums("random2", a, b);

        // Overflow boundaries on lanes 0-2, ordinary values elsewhere.
        for (int i = 0; i < N; i++) begin
            a[i] = i * 3 - 20;
            b[i] = 100 * i;
        end
        a[0] = 32767;  b[0] = 1;
        a[1] = -32768; b[1] = -1;
        a[2] = -5;     b[2] = 5;
        drive(a, b);
        @(posedge clk); #1;
        chk(  "wrap_pos", 0, int'(dw[0]), -32768);
        chk(  "wrap_neg", 1, int'(dw[1]), 32767);
        chk(  "wrap_zero", 2, int'(dw[2]), 0);
        chk(  "sat_pos",  0, int'(ds[0]), 32767);
        chk(  "sat_neg",  1, int'(ds[1]), -32768);
        chk(  "sat_zero", 2, int'(ds[2]), 0);
        chk_sums("boundary", a, b);

        // Pipelining: a new vector every cycle, each appears exactly once.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) begin
                a[i] = k; b[i] = i;
            end
            drive(a, b);
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                chk("pipe_wrap", i, int'(dw[i]), k + i);
                chk("pipe_sat",  i, int'(ds[i]), k + i);
            end
        end

        // Mid-run reset: outputs clear before the next edge.
        chk("pre_reset_nonzero", N-1, int'(dw[N-1]), 7 + N - 1);
        #2;
        rst = 1'b0;
        #1;
        chk_zero("midrun_reset");
        @(posedge clk); #1;
        chk_zero("midrun_reset_edge");
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            a[i] = 3; b[i] = 4;
        end
        drive(a, b);
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            chk("after_reset_wrap", i, int'(dw[i]), 7);
            chk("after_reset_sat",  i, int'(ds[i]), 7);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
